misr_sig_reg: RTL

Parametrised multiple-input signature register (MISR) with an automated compaction session controller. It is the next generation of the fixed 32-bit CRC_OUT signature chains in the s35932-family test logic. Width, polynomial, seed and session length are generic. A block of parallel response words is compacted into a signature, which is then compared against a golden value. The register also supports manual hold/compress/scan-shift/clear modes for test access.

---
 rtl/misr_pkg.sv | 49 ++++
 rtl/misr_core.sv | 50 +++++
 rtl/misr_sig_reg.sv | 125 ++++++++++++
 3 files changed

// File: rtl/misr_pkg.sv
// Shared definitions for the MISR signature register: mode codes, FSM states,
// core operation select and the reusable compaction step function.
package misr_pkg;

   // Widest signature the step function supports.
   localparam int unsigned MISR_MAX_W = 64;

   // Manual mode encodings on the mode input.
   localparam logic [1:0] MODE_HOLD     = 2'b00;
   localparam logic [1:0] MODE_COMPRESS = 2'b01;
   localparam logic [1:0] MODE_SHIFT    = 2'b10;
   localparam logic [1:0] MODE_CLEAR    = 2'b11;

   // Session controller states.
   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StCheck,
      StDone
   } misr_state_e;

   // Operation applied to the signature register in a given cycle.
   typedef enum logic [1:0] {
      CoreHold,
      CoreCompress,
      CoreShift,
      CoreLoad
   } core_op_e;

   // One compress step for a signature of 'width' bits held in the low bits of
   // a MISR_MAX_W vector: shift left, fold in POLY when the MSB falls out, XOR
   // in the data word. Bits above 'width' are cleared.
   function automatic logic [MISR_MAX_W-1:0] misr_step(
      input logic [MISR_MAX_W-1:0] sig,
      input logic [MISR_MAX_W-1:0] data,
      input logic [MISR_MAX_W-1:0] poly,
      input int unsigned           width
   );
      logic [MISR_MAX_W-1:0] one;
      logic [MISR_MAX_W-1:0] mask;
      logic [MISR_MAX_W-1:0] fb;
      one  = MISR_MAX_W'(1);
      // Shifting past the top yields zero, so width == MISR_MAX_W gives all ones.
      mask = (one << width) - one;
      fb   = ((sig & (one << (width - 1))) != '0) ? poly : '0;
      return ((sig << 1) ^ fb ^ data) & mask;
   endfunction

endpackage

// File: rtl/misr_core.sv
// Signature register with its step logic: hold, compress, serial shift or
// reload of the seed value, selected by op_i.
module misr_core
   import misr_pkg::*;
#(
   parameter int unsigned      WIDTH = 32,
   parameter logic [WIDTH-1:0] POLY  = '0,
   parameter logic [WIDTH-1:0] SEED  = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  core_op_e         op_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             scan_i,
   output logic [WIDTH-1:0] sig_o
);

   logic [WIDTH-1:0]      sig_q;
   logic [WIDTH-1:0]      sig_d;
   logic [MISR_MAX_W-1:0] step_full;
   logic [WIDTH-1:0]      step_sig;

   assign step_full = misr_step(MISR_MAX_W'(sig_q), MISR_MAX_W'(data_i),
                                MISR_MAX_W'(POLY), WIDTH);
   assign step_sig  = step_full[WIDTH-1:0];

   // Select the next signature value from the requested operation.
   always_comb begin
      sig_d = sig_q;
      unique case (op_i)
         CoreHold:     sig_d = sig_q;
         CoreCompress: sig_d = step_sig;
         CoreShift:    sig_d = {sig_q[WIDTH-2:0], scan_i};
         CoreLoad:     sig_d = SEED;
         default:      sig_d = sig_q;
      endcase
   end

   // Signature register; reset returns it to the seed.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sig_q <= SEED;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig_o = sig_q;

endmodule

// File: rtl/misr_sig_reg.sv
// Multiple-input signature register with a compaction session controller.
// In IDLE the manual mode drives the register; a start pulse runs a session
// that absorbs num_words valid words, compares against a golden value and
// pulses done.
module misr_sig_reg
   import misr_pkg::*;
#(
   parameter int unsigned      WIDTH = 32,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h0001_0809),
   parameter logic [WIDTH-1:0] SEED  = '0,
   parameter int unsigned      CNT_W = 16
) (
   input  logic             CK,
   input  logic             RESET,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_vld,
   input  logic             scan_in,
   output logic             scan_out,
   input  logic             start,
   input  logic [CNT_W-1:0] num_words,
   input  logic [WIDTH-1:0] golden,
   output logic [WIDTH-1:0] sig,
   output logic             busy,
   output logic             done,
   output logic             pass
);

   misr_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] target_q, target_d;
   logic [WIDTH-1:0] golden_q, golden_d;
   logic             pass_q, pass_d;
   core_op_e         core_op;
   logic [WIDTH-1:0] sig_w;

   misr_core #(
      .WIDTH (WIDTH),
      .POLY  (POLY),
      .SEED  (SEED)
   ) u_core (
      .clk_i  (CK),
      .rst_ni (RESET),
      .op_i   (core_op),
      .data_i (data_in),
      .scan_i (scan_in),
      .sig_o  (sig_w)
   );

   // Session FSM next state, counter/golden capture and core operation select.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      target_d = target_q;
      golden_d = golden_q;
      pass_d   = pass_q;
      core_op  = CoreHold;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               core_op  = CoreLoad;
               golden_d = golden;
               // A zero word count runs a one-word session.
               target_d = (num_words == '0) ? CNT_W'(1) : num_words;
               cnt_d    = '0;
               pass_d   = 1'b0;
               state_d  = StRun;
            end else begin
               unique case (mode)
                  MODE_HOLD:     core_op = CoreHold;
                  MODE_COMPRESS: core_op = data_vld ? CoreCompress : CoreHold;
                  MODE_SHIFT:    core_op = CoreShift;
                  MODE_CLEAR:    core_op = CoreLoad;
                  default:       core_op = CoreHold;
               endcase
            end
         end
         StRun: begin
            if (data_vld) begin
               core_op = CoreCompress;
               cnt_d   = cnt_q + CNT_W'(1);
               // Compare against target-1 so the counter never has to pass
               // the programmed count, even at the all-ones maximum.
               if (cnt_q == target_q - CNT_W'(1)) begin
                  state_d = StCheck;
               end
            end
         end
         StCheck: begin
            pass_d  = (sig_w == golden_q);
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Controller state registers.
   always_ff @(posedge CK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         target_q <= CNT_W'(1);
         golden_q <= '0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         target_q <= target_d;
         golden_q <= golden_d;
         pass_q   <= pass_d;
      end
   end

   assign sig      = sig_w;
   assign scan_out = sig_w[WIDTH-1];
   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StDone);
   assign pass     = pass_q;

endmodule
